// File: rtl/micro_pkg.sv
// Shared encodings for the 9-bit micro: opcodes, jump conditions and
// fetch-unit state values.
package micro_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_MOVE  = 3'b100;
  localparam logic [2:0] OP_MATH  = 3'b101;
  localparam logic [2:0] OP_JUMP  = 3'b110;

  localparam logic [8:0] OP_NOP_WORD = 9'h1FF;

  localparam logic [2:0] JC_ALWAYS = 3'b000;
  localparam logic [2:0] JC_Z      = 3'b001;
  localparam logic [2:0] JC_NZ     = 3'b011;

  typedef logic [1:0] state_t;

  localparam state_t ST_FETCH = 2'd0;
  localparam state_t ST_EXEC  = 2'd1;
  localparam state_t ST_HALT  = 2'd2;

  function automatic logic jump_cond_met(input logic [2:0] cond, input logic zero);
    case (cond)
      JC_ALWAYS: jump_cond_met = 1'b1;
      JC_Z:      jump_cond_met = zero;
      JC_NZ:     jump_cond_met = ~zero;
      default:   jump_cond_met = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational split of the instruction register into fields, plus the
// jump/NOP classification that the fetch unit consumes internally.
module instr_decoder
  import micro_pkg::*;
(
  input  logic [8:0] ir_i,
  input  logic       zero_i,
  output logic [2:0] opcode_o,
  output logic [2:0] field_a_o,
  output logic [2:0] field_b_o,
  output logic       is_jump_o,
  output logic       is_nop_o,
  output logic       jump_taken_o
);

  always_comb begin
    opcode_o     = ir_i[8:6];
    field_a_o    = ir_i[5:3];
    field_b_o    = ir_i[2:0];
    is_nop_o     = (ir_i == OP_NOP_WORD);
    is_jump_o    = (ir_i[8:6] == OP_JUMP);
    jump_taken_o = is_jump_o && jump_cond_met(ir_i[2:0], zero_i);
  end

endmodule

// File: rtl/fetch_unit.sv
// Program-ROM initiator: owns PC/IR, sequences FETCH/EXEC/HALT, resolves
// jumps and NOPs locally and hands datapath instructions over with valid/stall.
module fetch_unit
  import micro_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  output logic [7:0] o_Address,
  input  logic [8:0] i_Instruction,
  input  logic       i_Zero,
  input  logic       i_Stall,
  output logic       o_Valid,
  output logic [2:0] o_Opcode,
  output logic [2:0] o_FieldA,
  output logic [2:0] o_FieldB,
  output logic       o_Halt
);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [8:0] ir_q, ir_d;
  logic       is_jump, is_nop, jump_taken;

  instr_decoder u_dec (
    .ir_i         (ir_q),
    .zero_i       (i_Zero),
    .opcode_o     (o_Opcode),
    .field_a_o    (o_FieldA),
    .field_b_o    (o_FieldB),
    .is_jump_o    (is_jump),
    .is_nop_o     (is_nop),
    .jump_taken_o (jump_taken)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        ir_d    = i_Instruction;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (jump_taken) begin
          pc_d    = {5'b0, o_FieldA};
          state_d = ST_FETCH;
        end else if (is_jump || is_nop || !i_Stall) begin
          // Incrementing past the last ROM word stops sequencing instead of wrapping.
          if (pc_q == 8'hFF) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + 8'd1;
            state_d = ST_FETCH;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= OP_NOP_WORD;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign o_Address = pc_q;
  assign o_Valid   = (state_q == ST_EXEC) && !is_jump && !is_nop;
  assign o_Halt    = (state_q == ST_HALT);

endmodule
